// File: rtl/dcache_ctrl_if.sv
// Memory-side request bus of the data cache.
// The cache drives it through the master modport; the data memory answers through slave.
interface dcache_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [127:0]      mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits complete in the same cycle. Misses refill a 16 B line and then hit.
// Every store is written through to memory, and the CPU is stalled until memory is ready.
// Optional build macro DCACHE_STATS_EN adds saturating read hit and miss counters.
// Without that macro, the counter ports are tied to zero.
module dcache_ctrl #(
  parameter int ADDR_W = 10,
  parameter int LINES  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  dcache_ctrl_if.master     mem,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WTHRU} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [127:0]     data_q [LINES];

  // One-cycle flag: the store that just finished must retire, not be sent again.
  logic wr_done_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       word_sel;
  logic             hit;
  logic             fill_en;
  logic             wupd_en;

  assign idx      = cpu_addr[4 +: IDX_W];
  assign tag      = cpu_addr[ADDR_W-1 -: TAG_W];
  assign word_sel = cpu_addr[3:2];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);

  // Combinational lookup: return the selected word on a hit, otherwise return zero.
  assign cpu_rdata = hit ? data_q[idx][{word_sel, 5'b0} +: 32] : 32'h0;

  // Next-state and handshake decode. A write has priority over a simultaneous read.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d       = state_q;
    cpu_stall     = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    fill_en       = 1'b0;
    wupd_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_write) begin
          if (!wr_done_q) begin
            cpu_stall = 1'b1;
            state_d   = WTHRU;
          end
        end else if (cpu_read && !hit) begin
          cpu_stall = 1'b1;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        mem.mem_read = 1'b1;
        cpu_stall    = 1'b1;
        if (mem.mem_ready) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      WTHRU: begin
        mem.mem_write = 1'b1;
        cpu_stall     = 1'b1;
        if (mem.mem_ready) begin
          wupd_en = hit;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, the retire flag, and request address/data captured when leaving IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_done_q     <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
      state_q   <= state_d;
      wr_done_q <= (state_q == WTHRU) && mem.mem_ready;
      if (state_q == IDLE && state_d == REFILL) begin
        mem.mem_addr <= {cpu_addr[ADDR_W-1:4], 4'b0};
      end else if (state_q == IDLE && state_d == WTHRU) begin
        mem.mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b0};
        mem.mem_wdata <= cpu_wdata;
      end
    end
  end

  // Valid bits: cleared by reset, and set when a refill lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays: a refill writes the whole line, and a write hit patches one word.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; the valid bits alone make stale contents invisible.
    if (fill_en) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mem.mem_rdata;
    end else if (wupd_en) begin
      data_q[idx][{word_sel, 5'b0} +: 32] <= mem.mem_wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refill_done_q;
  logic [15:0] hit_q;
  logic [15:0] miss_q;

  // Saturating counters. The hit that retires a refilled read is not counted as a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refill_done_q <= 1'b0;
      hit_q         <= '0;
      miss_q        <= '0;
    end else begin
      refill_done_q <= fill_en;
      if (state_q == IDLE && cpu_read && !cpu_write && hit && !refill_done_q &&
          hit_q != 16'hFFFF) begin
        hit_q <= hit_q + 16'd1;
      end
      if (state_q == IDLE && state_d == REFILL && miss_q != 16'hFFFF) begin
        miss_q <= miss_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = 16'h0;
  assign miss_count = 16'h0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl.
// It contains a latency-programmable memory model, a directed vector table,
// a reset-during-refill sequence, and random traffic checked against a reference cache model.
module tb_dcache_ctrl;
`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cpu_read;
  logic        cpu_write;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  dcache_ctrl_if #(.ADDR_W(10)) mif ();

  dcache_ctrl #(.ADDR_W(10), .LINES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem        (mif),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Memory model: mem_ready is raised lat_n cycles after a request rises.
  logic [31:0] mem_words [256];
  int          lat_n = 3;
  int          lat_cnt;
  logic        req;

  assign req            = mif.mem_read || mif.mem_write;
  assign mif.mem_ready  = req && (lat_cnt == lat_n);
  assign mif.mem_rdata  = {mem_words[{mif.mem_addr[9:4], 2'd3}], mem_words[{mif.mem_addr[9:4], 2'd2}],
                           mem_words[{mif.mem_addr[9:4], 2'd1}], mem_words[{mif.mem_addr[9:4], 2'd0}]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lat_cnt <= 0;
    else if (req && !mif.mem_ready) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
  end

  always @(posedge clk) begin
    if (mif.mem_write && mif.mem_ready) mem_words[mif.mem_addr[9:2]] <= mif.mem_wdata;
  end

  // Bus monitor: counts request starts, records their address/data, and flags protocol breaches.
  int          rd_reqs = 0, wr_reqs = 0, viol = 0;
  logic [9:0]  last_rd_addr, last_wr_addr, prev_addr;
  logic [31:0] last_wr_data, prev_wdata;
  logic        prev_rd, prev_wr;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd <= 1'b0;
      prev_wr <= 1'b0;
    end else begin
      if (mif.mem_read && mif.mem_write) viol <= viol + 1;
      if ((mif.mem_read && prev_rd) || (mif.mem_write && prev_wr)) begin
        if (mif.mem_addr !== prev_addr || (mif.mem_write && mif.mem_wdata !== prev_wdata))
          viol <= viol + 1;
      end
      if (mif.mem_read && !prev_rd) begin
        rd_reqs      <= rd_reqs + 1;
        last_rd_addr <= mif.mem_addr;
      end
      if (mif.mem_write && !prev_wr) begin
        wr_reqs      <= wr_reqs + 1;
        last_wr_addr <= mif.mem_addr;
        last_wr_data <= mif.mem_wdata;
      end
      prev_rd    <= mif.mem_read;
      prev_wr    <= mif.mem_write;
      prev_addr  <= mif.mem_addr;
      prev_wdata <= mif.mem_wdata;
    end
  end

  // Each operation starts just after a rising edge, holds its request while stalled, and retires.
  task automatic run_op(input bit wr, input bit both, input logic [9:0] addr, input logic [31:0] wd,
                        output int stalls, output logic [31:0] rd);
    cpu_write = wr;
    cpu_read  = !wr || both;
    cpu_addr  = addr;
    cpu_wdata = wd;
    stalls    = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
      @(posedge clk);
      #1;
    end
    rd = cpu_rdata;
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    bit          both;
    logic [9:0]  addr;
    logic [31:0] wd;
    int          stall;
    logic [31:0] rd;
    int          rdreq;
    int          wrreq;
    logic [9:0]  maddr;
    int          hits;
    int          misses;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] ref_mem [256];
  bit          rv [8];
  int          rt [8];
  int          m_hits, m_misses;

  initial begin
    int          st, r0, w0, ehit, emiss, idx, tg, bad;
    logic [31:0] rd, d, exp_rd;
    logic [9:0]  a;
    bit          wr, both, is_hit;

    for (int i = 0; i < 256; i++) begin
      mem_words[i] = 32'(i * 4 + 'h100);
      ref_mem[i]   = 32'(i * 4 + 'h100);
    end

    //            wr both addr    wd     stall rd      rdq wrq maddr  hits miss
    vecs[0] = '{0, 0, 10'h014, 32'h0,  5, 32'h114, 1, 0, 10'h010, 0, 1};
    vecs[1] = '{0, 0, 10'h018, 32'h0,  0, 32'h118, 0, 0, 10'h000, 1, 1};
    vecs[2] = '{1, 0, 10'h014, 32'h8,  5, 32'h0,   0, 1, 10'h014, 1, 1};
    vecs[3] = '{0, 0, 10'h014, 32'h0,  0, 32'h8,   0, 0, 10'h000, 2, 1};
    vecs[4] = '{1, 1, 10'h200, 32'hAA, 5, 32'h0,   0, 1, 10'h200, 2, 1};
    vecs[5] = '{0, 0, 10'h200, 32'h0,  5, 32'hAA,  1, 0, 10'h200, 2, 2};
    vecs[6] = '{0, 0, 10'h014, 32'h0,  0, 32'h8,   0, 0, 10'h000, 3, 2};
    vecs[7] = '{0, 0, 10'h094, 32'h0,  5, 32'h194, 1, 0, 10'h090, 3, 3};
    vecs[8] = '{0, 0, 10'h014, 32'h0,  5, 32'h8,   1, 0, 10'h010, 3, 4};

    rst_n = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_mem_read",   32'(mif.mem_read),  0);
    check("rst_mem_write",  32'(mif.mem_write), 0);
    check("rst_mem_addr",   32'(mif.mem_addr),  0);
    check("rst_mem_wdata",  mif.mem_wdata,      0);
    check("rst_cpu_stall",  32'(cpu_stall),     0);
    check("rst_cpu_rdata",  cpu_rdata,          0);
    check("rst_hit_count",  32'(hit_count),     0);
    check("rst_miss_count", 32'(miss_count),    0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed scenarios with memory latency 3.
    foreach (vecs[i]) begin
      r0 = rd_reqs;
      w0 = wr_reqs;
      run_op(vecs[i].wr, vecs[i].both, vecs[i].addr, vecs[i].wd, st, rd);
      if (vecs[i].wr) ref_mem[vecs[i].addr[9:2]] = vecs[i].wd;
      check($sformatf("v%0d_stall", i), 32'(st), 32'(vecs[i].stall));
      if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
      check($sformatf("v%0d_rd_reqs", i), 32'(rd_reqs - r0), 32'(vecs[i].rdreq));
      check($sformatf("v%0d_wr_reqs", i), 32'(wr_reqs - w0), 32'(vecs[i].wrreq));
      if (vecs[i].rdreq != 0) check($sformatf("v%0d_rd_addr", i), 32'(last_rd_addr), 32'(vecs[i].maddr));
      if (vecs[i].wrreq != 0) begin
        check($sformatf("v%0d_wr_addr", i), 32'(last_wr_addr), 32'(vecs[i].maddr));
        check($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].wd);
      end
      check($sformatf("v%0d_hits", i),   32'(hit_count),  STATS ? 32'(vecs[i].hits)   : 0);
      check($sformatf("v%0d_misses", i), 32'(miss_count), STATS ? 32'(vecs[i].misses) : 0);
    end

    // Reset during the second cycle of a refill.
    cpu_read = 1'b1;
    cpu_addr = 10'h300;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_read",   32'(mif.mem_read), 0);
    check("midrst_mem_addr",   32'(mif.mem_addr), 0);
    check("midrst_miss_count", 32'(miss_count),   0);
    cpu_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    r0 = rd_reqs;
    run_op(1'b0, 1'b0, 10'h018, 32'h0, st, rd);
    check("postrst_stall",   32'(st), 5);
    check("postrst_rdata",   rd, 32'h118);
    check("postrst_rd_reqs", 32'(rd_reqs - r0), 1);

    // Random traffic against a behavioural cache: lines are tracked by index and tag.
    // Because stores are written through, cached data always equals the reference memory.
    for (int i = 0; i < 8; i++) rv[i] = 1'b0;
    m_hits   = 0;
    m_misses = 1;
    rv[1]    = 1'b1;
    rt[1]    = 0;
    for (int k = 0; k < 80; k++) begin
      wr     = ($urandom_range(0, 2) == 0);
      both   = wr && ($urandom_range(0, 1) == 1);
      a      = 10'($urandom_range(0, 127) * 4);
      d      = $urandom;
      lat_n  = $urandom_range(0, 3);
      idx    = (int'(a) / 16) % 8;
      tg     = int'(a) / 128;
      is_hit = rv[idx] && (rt[idx] == tg);
      exp_rd = ref_mem[a[9:2]];
      if (wr) begin
        ehit = lat_n + 2;
        ref_mem[a[9:2]] = d;
      end else if (is_hit) begin
        ehit = 0;
        m_hits++;
      end else begin
        ehit = lat_n + 2;
        m_misses++;
        rv[idx] = 1'b1;
        rt[idx] = tg;
      end
      run_op(wr, both, a, d, st, rd);
      check($sformatf("rnd%0d_stall", k), 32'(st), 32'(ehit));
      if (!wr) check($sformatf("rnd%0d_rdata", k), rd, exp_rd);
    end
    ehit  = STATS ? m_hits : 0;
    emiss = STATS ? m_misses : 0;
    check("rnd_hit_count",  32'(hit_count),  32'(ehit));
    check("rnd_miss_count", 32'(miss_count), 32'(emiss));

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem_words[i] !== ref_mem[i]) bad++;
    check("mem_contents", 32'(bad), 0);
    check("bus_protocol", 32'(viol), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time limit, so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
